// File: rtl/fa_bist.sv
// rtl/fa_bist.sv - built-in self-test controller for a single-bit full adder
module fa_bist #(
    parameter int          NUM_VECTORS = 256,
    parameter int          CNT_W       = 16,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    output logic             in1,
    output logic             in2,
    output logic             cin,
    input  logic             sum,
    input  logic             carry,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_fail_vec,
    output logic [4:0]       first_fail_data
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] LFSR_IDX = CNT_W'(8);

    state_t           state;
    state_t           state_next;
    logic [7:0]       lfsr;
    logic [7:0]       lfsr_adv;
    logic [2:0]       stim;
    logic [1:0]       expected;
    logic             mismatch;
    logic             last;
    logic [CNT_W-1:0] next_idx;

    assign {in1, in2, cin} = stim;

    // vec_cnt doubles as the index of the vector currently on the stimulus outputs
    always_comb begin
        expected = {1'b0, stim[2]} + {1'b0, stim[1]} + {1'b0, stim[0]};
        mismatch = ({carry, sum} !== expected);
        last     = (vec_cnt == LAST_IDX);
        next_idx = vec_cnt + 1'b1;
        lfsr_adv = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            stim            <= 3'b000;
            lfsr            <= LFSR_SEED;
            vec_cnt         <= '0;
            err_cnt         <= '0;
            pass            <= 1'b0;
            first_fail_vec  <= '0;
            first_fail_data <= 5'b00000;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        stim            <= 3'b000;
                        lfsr            <= LFSR_SEED;
                        vec_cnt         <= '0;
                        err_cnt         <= '0;
                        pass            <= 1'b0;
                        first_fail_vec  <= '0;
                        first_fail_data <= 5'b00000;
                    end
                end
                RUN: begin
                    if (mismatch) begin
                        err_cnt <= err_cnt + 1'b1;
                        if (err_cnt == '0) begin
                            first_fail_vec  <= vec_cnt;
                            first_fail_data <= {stim, carry, sum};
                        end
                    end
                    vec_cnt <= next_idx;
                    // exhaustive phase first, then the seed itself, then one LFSR step per vector
                    if (last) begin
                        stim <= 3'b000;
                        pass <= (err_cnt == '0) && !mismatch;
                    end else if (next_idx < LFSR_IDX) begin
                        stim <= next_idx[2:0];
                    end else if (next_idx == LFSR_IDX) begin
                        stim <= lfsr[2:0];
                    end else begin
                        lfsr <= lfsr_adv;
                        stim <= lfsr_adv[2:0];
                    end
                end
                default: stim <= 3'b000;
            endcase
        end
    end

endmodule

// File: tb/tb_fa_bist.sv
// tb/tb_fa_bist.sv - randomized self-checking bench for fa_bist against a position-based model
module tb_fa_bist;

    logic        clk = 1'b0;
    logic [1:0]  rst = 2'b11;
    logic [1:0]  start = 2'b00;
    int          mode [2] = '{0, 0};
    logic        in1 [2];
    logic        in2 [2];
    logic        cin [2];
    logic        sum [2];
    logic        carry [2];
    logic        busy [2];
    logic        done [2];
    logic        pass [2];
    logic [15:0] vc [2];
    logic [15:0] ec [2];
    logic [15:0] ffv [2];
    logic [4:0]  ffd [2];

    int checks = 0;
    int failures = 0;
    bit armed = 1'b0;

    always #5 clk = ~clk;

    // instance 0 runs 8 vectors, instance 1 runs 256; mode 1 = sum stuck 0, mode 2 = carry inverted
    for (genvar g = 0; g < 2; g++) begin : g_dut
        fa_bist #(.NUM_VECTORS(g == 0 ? 8 : 256)) u_dut (
            .sys_clk(clk), .sys_rst(rst[g]), .start(start[g]),
            .in1(in1[g]), .in2(in2[g]), .cin(cin[g]), .sum(sum[g]), .carry(carry[g]),
            .busy(busy[g]), .done(done[g]), .pass(pass[g]),
            .vec_cnt(vc[g]), .err_cnt(ec[g]), .first_fail_vec(ffv[g]), .first_fail_data(ffd[g])
        );
        assign sum[g]   = (mode[g] == 1) ? 1'b0 : (in1[g] ^ in2[g] ^ cin[g]);
        assign carry[g] = ((in1[g] & in2[g]) | (in1[g] & cin[g]) | (in2[g] & cin[g])) ^ (mode[g] == 2);
    end

    logic [2:0] seq [256];
    int         pos [2] = '{-1, -1};
    int         m_vc [2] = '{0, 0};
    int         m_err [2] = '{0, 0};
    int         m_ffv [2] = '{0, 0};
    logic [4:0] m_ffd [2] = '{5'd0, 5'd0};
    logic       m_pass [2] = '{1'b0, 1'b0};

    function automatic int nv(input int i);
        return (i == 0) ? 8 : 256;
    endfunction

    function automatic logic [2:0] vec_of(input int i);
        return (i < 8) ? i[2:0] : seq[i-8];
    endfunction

    function automatic logic [1:0] resp(input logic [2:0] v, input int m);
        logic s;
        logic c;
        s = (m == 1) ? 1'b0 : (v[2] ^ v[1] ^ v[0]);
        c = ((v[2] + v[1] + v[0]) >= 2) ^ (m == 2);
        return {c, s};
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h expected=%0h at %0t", nm, i, act, exp, $time);
        end
    endtask

    task automatic clear_model(input int i);
        m_vc[i] = 0; m_err[i] = 0; m_ffv[i] = 0; m_ffd[i] = 5'd0; m_pass[i] = 1'b0;
    endtask

    // model: pos = cycles since the accepted start, -1 when idle
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin : model
            logic [2:0] v;
            logic [1:0] r;
            int         e;
            if (rst[i]) begin
                pos[i] = -1;
                clear_model(i);
            end else if (pos[i] < 0) begin
                if (start[i]) begin
                    pos[i] = 0;
                    clear_model(i);
                end
            end else if (pos[i] < nv(i)) begin
                v = vec_of(pos[i]);
                r = resp(v, mode[i]);
                e = v[2] + v[1] + v[0];
                if (int'(r) != e) begin
                    if (m_err[i] == 0) begin
                        m_ffv[i] = pos[i];
                        m_ffd[i] = {v, r};
                    end
                    m_err[i]++;
                end
                m_vc[i]++;
                pos[i]++;
                if (pos[i] == nv(i)) m_pass[i] = (m_err[i] == 0);
            end else begin
                pos[i] = -1;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 2; i++) begin : cmp
                logic       eb;
                logic [2:0] es;
                eb = (pos[i] >= 0) && (pos[i] < nv(i));
                es = eb ? vec_of(pos[i]) : 3'b000;
                chk("busy", i, busy[i], eb);
                chk("done", i, done[i], pos[i] == nv(i));
                chk("stim", i, {in1[i], in2[i], cin[i]}, es);
                chk("pass", i, pass[i], m_pass[i]);
                chk("vec_cnt", i, vc[i], m_vc[i]);
                chk("err_cnt", i, ec[i], m_err[i]);
                chk("first_fail_vec", i, ffv[i], m_ffv[i]);
                chk("first_fail_data", i, ffd[i], m_ffd[i]);
            end
        end
    end

    task automatic do_run(input int i, input int m, input int glitch, input int rst_at,
                          output int busy_n, output int done_n, output int done_at,
                          output logic [2:0] s8, output logic [2:0] s9);
        int n;
        n = nv(i);
        mode[i] = m;
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
        busy_n = 0; done_n = 0; done_at = -1; s8 = 3'b000; s9 = 3'b000;
        for (int t = 0; t < n + 4; t++) begin
            if (busy[i]) busy_n++;
            if (done[i]) begin
                done_n++;
                if (done_at < 0) done_at = t;
            end
            if (t == 8) s8 = {in1[i], in2[i], cin[i]};
            if (t == 9) s9 = {in1[i], in2[i], cin[i]};
            start[i] = (t == glitch);
            rst[i] = (t == rst_at);
            @(negedge clk);
        end
        start[i] = 1'b0;
        rst[i] = 1'b0;
    endtask

    initial begin
        int bn, dn, da, ri, rm, rg, rr;
        logic [2:0] s8, s9;
        logic [7:0] l;
        l = 8'hA5;
        for (int k = 0; k < 256; k++) begin
            seq[k] = l[2:0];
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        end
        chk("model_seq0", 0, seq[0], 3'b101);
        chk("model_seq1", 0, seq[1], 3'b010);

        repeat (3) @(negedge clk);
        armed = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_busy", i, busy[i], 1'b0);
            chk("reset_stim", i, {in1[i], in2[i], cin[i]}, 3'b000);
            chk("reset_vec_cnt", i, vc[i], 16'd0);
        end
        rst = 2'b00;
        @(negedge clk);

        do_run(0, 0, -1, -1, bn, dn, da, s8, s9);
        chk("good_busy_cycles", 0, bn, 8);
        chk("good_done_pulses", 0, dn, 1);
        chk("good_done_at", 0, da, 8);
        chk("good_pass", 0, pass[0], 1'b1);
        chk("good_err", 0, ec[0], 16'd0);
        chk("good_vec", 0, vc[0], 16'd8);

        do_run(0, 1, -1, -1, bn, dn, da, s8, s9);
        chk("stuck_err", 0, ec[0], 16'd4);
        chk("stuck_ffv", 0, ffv[0], 16'd1);
        chk("stuck_ffd", 0, ffd[0], 5'b00100);
        chk("stuck_pass", 0, pass[0], 1'b0);

        do_run(0, 2, -1, -1, bn, dn, da, s8, s9);
        chk("cinv_err", 0, ec[0], 16'd8);
        chk("cinv_ffv", 0, ffv[0], 16'd0);
        chk("cinv_ffd", 0, ffd[0], 5'b00010);

        do_run(1, 0, -1, -1, bn, dn, da, s8, s9);
        chk("lfsr_vec8", 1, s8, 3'b101);
        chk("lfsr_vec9", 1, s9, 3'b010);
        chk("long_pass", 1, pass[1], 1'b1);
        chk("long_vec", 1, vc[1], 16'd256);
        chk("long_busy_cycles", 1, bn, 256);

        do_run(0, 0, 2, -1, bn, dn, da, s8, s9);
        chk("glitch_done_pulses", 0, dn, 1);
        chk("glitch_vec", 0, vc[0], 16'd8);
        chk("glitch_busy_cycles", 0, bn, 8);

        do_run(0, 2, 4, 4, bn, dn, da, s8, s9);
        chk("rst_done_pulses", 0, dn, 0);
        chk("rst_vec", 0, vc[0], 16'd0);
        chk("rst_err", 0, ec[0], 16'd0);
        do_run(0, 2, -1, -1, bn, dn, da, s8, s9);
        chk("after_rst_err", 0, ec[0], 16'd8);

        mode[0] = 0;
        start[0] = 1'b1;
        dn = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (done[0]) dn++;
        end
        start[0] = 1'b0;
        repeat (12) @(negedge clk);
        chk("held_start_done_pulses", 0, dn, 3);

        repeat (14) begin
            ri = ($urandom_range(0, 4) == 0) ? 1 : 0;
            rm = $urandom_range(0, 2);
            rr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nv(ri) + 2) : -1;
            rg = (rr < 0 && $urandom_range(0, 1) == 1) ? $urandom_range(0, nv(ri) - 1) : -1;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_run(ri, rm, rg, rr, bn, dn, da, s8, s9);
            if (rr < 0) begin
                chk("rand_done_pulses", ri, dn, 1);
                chk("rand_vec", ri, vc[ri], nv(ri));
            end
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
